// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: NUM_CH H-bridge PWM channels with per-period ramp limiting,
// dead time on direction reversal and a level-sensitive emergency stop.
module motor_drive_ctrl #(
   parameter int NUM_CH    = 2,
   parameter int WIDTH     = 11,
   parameter int RAMP_STEP = 64,
   parameter int DEAD_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] cmd,
   input  logic                    cmd_vld,
   input  logic                    estop,
   output logic [NUM_CH-1:0]       fwd,
   output logic [NUM_CH-1:0]       rev,
   output logic [NUM_CH-1:0]       at_target,
   output logic                    pwm_wrap
);

   localparam int PW = WIDTH - 1;
   localparam logic [PW-1:0]         MAX     = {PW{1'b1}};
   localparam logic [PW-1:0]         DEAD_LD = PW'(DEAD_CYC);
   localparam logic signed [WIDTH:0] STEP    = (WIDTH+1)'(RAMP_STEP);

   typedef enum logic [1:0] {
      ST_BRAKE = 2'd0,
      ST_FWD   = 2'd1,
      ST_REV   = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   logic [PW-1:0] pwm_cnt;

   assign pwm_wrap = (pwm_cnt == MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PW'(1);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic signed [WIDTH-1:0] cmd_ch;
      logic signed [WIDTH-1:0] target_q;
      logic signed [WIDTH-1:0] eff_q;
      logic signed [WIDTH-1:0] eff_ramp;
      logic signed [WIDTH:0]   te;
      logic signed [WIDTH:0]   ee;
      logic signed [WIDTH:0]   diff;
      logic signed [WIDTH:0]   mag;
      logic [WIDTH-1:0]        abs_eff;
      logic [PW-1:0]           duty;
      logic [PW-1:0]           dcnt_q;
      logic [PW-1:0]           dcnt_d;
      logic                    eff_pos;
      logic                    eff_neg;
      logic                    eff_zero;
      state_t                  state_q;
      state_t                  state_d;
      logic                    fwd_d;
      logic                    rev_d;
      logic                    fwd_q;
      logic                    rev_q;
      logic                    at_q;

      assign cmd_ch = cmd[i*WIDTH +: WIDTH];

      // One extra bit so target-eff never overflows, even across full scale.
      assign te   = {target_q[WIDTH-1], target_q};
      assign ee   = {eff_q[WIDTH-1], eff_q};
      assign diff = te - ee;
      assign mag  = diff[WIDTH] ? -diff : diff;

      always_comb begin
         eff_ramp = target_q;
         if (RAMP_STEP != 0 && mag > STEP) begin
            if (diff[WIDTH]) begin
               eff_ramp = eff_q - STEP[WIDTH-1:0];
            end else begin
               eff_ramp = eff_q + STEP[WIDTH-1:0];
            end
         end
      end

      assign eff_neg  = eff_q[WIDTH-1];
      assign eff_zero = (eff_q == '0);
      assign eff_pos  = !eff_neg && !eff_zero;

      // Most negative command has no positive twin; it saturates to full duty.
      assign abs_eff = eff_neg ? -eff_q : eff_q;
      assign duty    = abs_eff[PW] ? MAX : abs_eff[PW-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_BRAKE;
            dcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         dcnt_d  = dcnt_q;
         fwd_d   = 1'b0;
         rev_d   = 1'b0;
         case (state_q)
            ST_BRAKE: begin
               if (eff_pos) state_d = ST_FWD;
               else if (eff_neg) state_d = ST_REV;
            end
            ST_FWD: begin
               if (eff_zero) begin
                  state_d = ST_BRAKE;
               end else if (eff_neg) begin
                  state_d = ST_DEAD;
                  dcnt_d  = DEAD_LD;
               end
            end
            ST_REV: begin
               if (eff_zero) begin
                  state_d = ST_BRAKE;
               end else if (eff_pos) begin
                  state_d = ST_DEAD;
                  dcnt_d  = DEAD_LD;
               end
            end
            default: begin
               if (dcnt_q <= PW'(1)) begin
                  dcnt_d = '0;
                  if (eff_pos) state_d = ST_FWD;
                  else if (eff_neg) state_d = ST_REV;
                  else state_d = ST_BRAKE;
               end else begin
                  dcnt_d = dcnt_q - PW'(1);
               end
            end
         endcase
         if (estop) begin
            state_d = ST_BRAKE;
            dcnt_d  = '0;
         end
         // Pins follow the state being entered so a reversal never leaks one
         // cycle of the old direction and the dead window is exactly DEAD_CYC.
         case (state_d)
            ST_BRAKE: begin
               fwd_d = 1'b1;
               rev_d = 1'b1;
            end
            ST_FWD:  fwd_d = (pwm_cnt < duty);
            ST_REV:  rev_d = (pwm_cnt < duty);
            default: ;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            target_q <= '0;
            eff_q    <= '0;
            fwd_q    <= 1'b0;
            rev_q    <= 1'b0;
            at_q     <= 1'b1;
         end else begin
            fwd_q <= fwd_d;
            rev_q <= rev_d;
            at_q  <= (eff_q == target_q);
            if (estop) begin
               target_q <= '0;
               eff_q    <= '0;
            end else begin
               if (cmd_vld) target_q <= cmd_ch;
               if (pwm_wrap) eff_q <= eff_ramp;
            end
         end
      end

      assign fwd[i]       = fwd_q;
      assign rev[i]       = rev_q;
      assign at_target[i] = at_q;
   end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: three instances (ramp 64, no ramp, ramp 128) on
// shared stimulus; per-period high counts are scored against queued expectations.
module tb_motor_drive_ctrl;

   localparam int NCH = 2;
   localparam int W   = 11;
   localparam int PER = 1024;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_vld;
   logic             estop;
   logic [NCH*W-1:0] cmd;
   logic [NCH-1:0]   fwd_a, rev_a, at_a;
   logic [NCH-1:0]   fwd_b, rev_b, at_b;
   logic [NCH-1:0]   fwd_c, rev_c, at_c;
   logic             wrap_a, wrap_b, wrap_c;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   motor_drive_ctrl #(.NUM_CH(2), .WIDTH(11), .RAMP_STEP(64), .DEAD_CYC(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld), .estop(estop),
      .fwd(fwd_a), .rev(rev_a), .at_target(at_a), .pwm_wrap(wrap_a));

   motor_drive_ctrl #(.NUM_CH(2), .WIDTH(11), .RAMP_STEP(0), .DEAD_CYC(16)) u_r0 (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld), .estop(estop),
      .fwd(fwd_b), .rev(rev_b), .at_target(at_b), .pwm_wrap(wrap_b));

   motor_drive_ctrl #(.NUM_CH(2), .WIDTH(11), .RAMP_STEP(128), .DEAD_CYC(16)) u_r128 (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld), .estop(estop),
      .fwd(fwd_c), .rev(rev_c), .at_target(at_c), .pwm_wrap(wrap_c));

   typedef struct {
      int         sel;
      int         c0;
      int         c1;
      int         settle;
      int         f0;
      int         r0;
      int         f1;
      int         r1;
      logic [1:0] at;
   } vec_t;

   vec_t tbl[6];
   vec_t exp_q[$];
   int   duty_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0] probe(input int sel);
      case (sel)
         0:       return {at_a, rev_a, fwd_a};
         1:       return {at_b, rev_b, fwd_b};
         default: return {at_c, rev_c, fwd_c};
      endcase
   endfunction

   // Returns at the negedge inside the pwm_cnt==MAX cycle.
   task automatic wait_wrap();
      bit seen = 1'b0;
      for (int k = 0; k < 2*PER; k++) begin
         @(negedge clk);
         if (wrap_a) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_vec++;
         n_bad++;
         $display("FAIL wrap_timeout: got no pwm_wrap, want one within %0d cycles", 2*PER);
      end
   endtask

   task automatic measure(input int sel, output int f0, output int r0, output int f1,
                          output int r1, output logic [1:0] at, output int first_r0);
      logic [5:0] p;
      f0 = 0; r0 = 0; f1 = 0; r1 = 0; at = 2'b00; first_r0 = -1;
      for (int k = 0; k < PER; k++) begin
         @(negedge clk);
         p = probe(sel);
         if (k == 0) at = p[5:4];
         f0 += int'(p[0]);
         f1 += int'(p[1]);
         r0 += int'(p[2]);
         r1 += int'(p[3]);
         if (p[2] && first_r0 < 0) first_r0 = k;
      end
   endtask

   task automatic latch(input int c0, input int c1);
      wait_wrap();
      @(negedge clk);
      cmd     = {W'(c1), W'(c0)};
      cmd_vld = 1'b1;
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic compare_vec(input string tag, input vec_t e, input int f0, input int r0,
                              input int f1, input int r1, input logic [1:0] at);
      check($sformatf("%s fwd0_hi", tag), f0, e.f0);
      check($sformatf("%s rev0_hi", tag), r0, e.r0);
      check($sformatf("%s fwd1_hi", tag), f1, e.f1);
      check($sformatf("%s rev1_hi", tag), r1, e.r1);
      check($sformatf("%s at_target", tag), int'(at), int'(e.at));
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      int f0, r0, f1, r1, fr;
      logic [1:0] at;
      vec_t e;
      latch(v.c0, v.c1);
      exp_q.push_back(v);
      repeat (v.settle) wait_wrap();
      wait_wrap();
      @(negedge clk);
      measure(v.sel, f0, r0, f1, r1, at, fr);
      e = exp_q.pop_front();
      compare_vec(tag, e, f0, r0, f1, r1, at);
   endtask

   initial begin
      int f0, r0, f1, r1, fr;
      logic [1:0] at;
      vec_t e;

      rst_n   = 1'b0;
      cmd     = '0;
      cmd_vld = 1'b0;
      estop   = 1'b0;

      //            sel    c0     c1 settle   f0    r0    f1    r1   at
      tbl[0] = '{1,   512,     0, 0,  512,    0, 1024, 1024, 2'b11};
      tbl[1] = '{1, -1024,  1023, 1,    0, 1023, 1023,    0, 2'b11};
      tbl[2] = '{1,  1023, -1024, 1, 1023,    0,    0, 1023, 2'b11};
      tbl[3] = '{1,     0,     0, 0, 1024, 1024, 1024, 1024, 2'b11};
      tbl[4] = '{1,  -300,     5, 0,    0,  300,    5,    0, 2'b11};
      tbl[5] = '{2,    64,     0, 3,   64,    0, 1024, 1024, 2'b11};

      repeat (3) @(negedge clk);
      check("rst fwd", int'(fwd_a), 0);
      check("rst rev", int'(rev_a), 0);
      check("rst at_target", int'(at_a), 3);
      check("rst pwm_wrap", int'(wrap_a), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst fwd", int'(fwd_a), 3);
      check("post_rst rev", int'(rev_a), 3);
      check("post_rst at_target", int'(at_a), 3);

      for (int i = 0; i < 6; i++) begin
         apply_vec($sformatf("vec%0d", i), tbl[i]);
      end

      // Reversal under ramp 128: +64 -> -64 in one step, dead window then reverse PWM.
      latch(-64, 0);
      exp_q.push_back('{2, -64, 0, 0, 0, 64, 0, 0, 2'b11});
      wait_wrap();
      @(negedge clk);
      measure(2, f0, r0, f1, r1, at, fr);
      check("rev dead_cycles", fr, 16);
      check("rev first fwd0_hi", f0, 0);
      check("rev first rev0_hi", r0, 64 - 16);
      measure(2, f0, r0, f1, r1, at, fr);
      e = exp_q.pop_front();
      check("rev steady fwd0_hi", f0, e.f0);
      check("rev steady rev0_hi", r0, e.r0);

      // Reset asserted in the middle of a dead window.
      latch(64, 0);
      wait_wrap();
      @(negedge clk);
      repeat (6) @(negedge clk);
      check("dead pins_low", int'({fwd_c[0], rev_c[0]}), 0);
      rst_n = 1'b0;
      #1;
      check("async_rst fwd_rev", int'({fwd_a, rev_a}), 0);
      check("async_rst r128 fwd_rev", int'({fwd_c, rev_c}), 0);
      check("async_rst r128 at_target", int'(at_c), 3);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release r128 fwd", int'(fwd_c), 3);
      check("rst_release r128 rev", int'(rev_c), 3);
      repeat (20) @(negedge clk);
      check("rst_hold r128 fwd", int'(fwd_c), 3);

      // Ramp 64: 0 -> +256 over four periods.
      latch(256, 0);
      duty_q.push_back(64);
      duty_q.push_back(128);
      duty_q.push_back(192);
      duty_q.push_back(256);
      wait_wrap();
      @(negedge clk);
      for (int w = 0; w < 4; w++) begin
         measure(0, f0, r0, f1, r1, at, fr);
         check($sformatf("ramp%0d fwd0_hi", w), f0, duty_q.pop_front());
         check($sformatf("ramp%0d at_target0", w), int'(at[0]), (w == 3) ? 1 : 0);
      end

      apply_vec("vec6", '{0, 200, -100, 1, 200, 0, 0, 100, 2'b11});

      // Emergency stop mid-PWM with a command that must be ignored.
      wait_wrap();
      @(negedge clk);
      repeat (50) @(negedge clk);
      check("pre_estop fwd", int'(fwd_a), 1);
      check("pre_estop rev", int'(rev_a), 2);
      estop   = 1'b1;
      cmd     = {W'(500), W'(500)};
      cmd_vld = 1'b1;
      @(negedge clk);
      check("estop fwd", int'(fwd_a), 3);
      check("estop rev", int'(rev_a), 3);
      repeat (2) @(negedge clk);
      estop   = 1'b0;
      cmd_vld = 1'b0;
      exp_q.push_back('{0, 0, 0, 0, 1024, 1024, 1024, 1024, 2'b11});
      wait_wrap();
      @(negedge clk);
      measure(0, f0, r0, f1, r1, at, fr);
      e = exp_q.pop_front();
      compare_vec("post_estop", e, f0, r0, f1, r1, at);

      latch(128, 0);
      duty_q.push_back(64);
      duty_q.push_back(128);
      wait_wrap();
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         measure(0, f0, r0, f1, r1, at, fr);
         check($sformatf("reramp%0d fwd0_hi", w), f0, duty_q.pop_front());
         check($sformatf("reramp%0d at_target0", w), int'(at[0]), (w == 1) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
